// File: rtl/disp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : disp_pkg
// Description : Shared constants and types for the seven-segment display
//               control block: MMIO register addresses, saturation limit,
//               double-dabble iteration count and the FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package disp_pkg;

    // MMIO register select values on cpu_addr
    localparam logic [1:0] ADDR_VAL   = 2'd0;
    localparam logic [1:0] ADDR_BLINK = 2'd1;
    localparam logic [1:0] ADDR_MODE  = 2'd2;
    localparam logic [1:0] ADDR_RAW   = 2'd3;

    // Largest value that fits in four decimal digits
    localparam int MAX_VAL = 9999;

    // One double-dabble iteration per binary input bit
    localparam int ITER = 14;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage : disp_pkg
`default_nettype wire

// File: rtl/disp_ctrl_bin2bcd_step.sv
`default_nettype none
// ============================================================================
// Module      : bin2bcd_step
// Description : One combinational double-dabble iteration. Every BCD nibble
//               that is 5 or more gets +3, then the {bcd,bin} pair is
//               shifted left by one bit.
// Ports       : i_bcd / i_bin   - current BCD accumulator and binary remainder
//               o_bcd / o_bin   - accumulator and remainder after the step
// Revision    : 1.0 - initial release
// ============================================================================
module bin2bcd_step #(
    parameter int BIN_W = 14
) (
    input  logic [15:0]      i_bcd,
    input  logic [BIN_W-1:0] i_bin,
    output logic [15:0]      o_bcd,
    output logic [BIN_W-1:0] o_bin
);

    logic [15:0] w_adj;

    // Pre-shift correction: a nibble >= 5 would become >= 10 after doubling,
    // so adding 3 first makes the shift carry into the next decimal digit.
    for (genvar i = 0; i < 4; i++) begin : g_nibble
        assign w_adj[4*i +: 4] = (i_bcd[4*i +: 4] >= 4'd5) ? (i_bcd[4*i +: 4] + 4'd3)
                                                           : i_bcd[4*i +: 4];
    end

    assign o_bcd = {w_adj[14:0], i_bin[BIN_W-1]};
    assign o_bin = {i_bin[BIN_W-2:0], 1'b0};

endmodule : bin2bcd_step
`default_nettype wire

// File: rtl/disp_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : disp_ctrl
// Description : Control and sequencing for the 4-digit seven-segment display.
//               Owns the digit registers and blink mask, arbitrates between
//               the CPU MMIO store port and a debug value source, and converts
//               binary values to BCD with a 14-cycle double-dabble sequencer.
// Ports       : clock, reset_n           - clock, synchronous active-low reset
//               cpu_we/cpu_addr/cpu_wdata - MMIO store port
//               dbg_req/dbg_value/dbg_ack - debug value source handshake
//               busy                      - conversion in progress
//               mode                      - 0 CPU owns display, 1 debug owns
//               x1..x4, blink             - digits (units..thousands), blink
// Revision    : 1.0 - initial release
// ============================================================================
module disp_ctrl #(
    parameter int VAL_W   = 14,
    parameter int MAX_VAL = 9999
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             cpu_we,
    input  logic [1:0]       cpu_addr,
    input  logic [31:0]      cpu_wdata,
    input  logic             dbg_req,
    input  logic [VAL_W-1:0] dbg_value,
    output logic             dbg_ack,
    output logic             busy,
    output logic             mode,
    output logic [3:0]       x1,
    output logic [3:0]       x2,
    output logic [3:0]       x3,
    output logic [3:0]       x4,
    output logic [3:0]       blink
);

    import disp_pkg::*;

    state_t           r_state;
    logic [15:0]      r_bcd;
    logic [VAL_W-1:0] r_bin;
    logic [3:0]       r_iter;
    logic [VAL_W-1:0] r_pend_val;
    logic             r_pend_vld;

    logic [15:0]      w_bcd_next;
    logic [VAL_W-1:0] w_bin_next;
    logic [VAL_W-1:0] w_cpu_sat;
    logic [VAL_W-1:0] w_dbg_sat;

    // Saturation compares the full 32-bit word, so a large value whose low
    // bits happen to be small still clamps to the limit.
    assign w_cpu_sat = (cpu_wdata > 32'(MAX_VAL)) ? VAL_W'(MAX_VAL) : cpu_wdata[VAL_W-1:0];
    assign w_dbg_sat = (dbg_value > VAL_W'(MAX_VAL)) ? VAL_W'(MAX_VAL) : dbg_value;

    // Acknowledge in the same cycle the debug value is sampled.
    assign dbg_ack = (r_state == IDLE) && mode && dbg_req;
    assign busy    = (r_state != IDLE);

    bin2bcd_step #(
        .BIN_W (VAL_W)
    ) u_step (
        .i_bcd (r_bcd),
        .i_bin (r_bin),
        .o_bcd (w_bcd_next),
        .o_bin (w_bin_next)
    );

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_bcd      <= '0;
            r_bin      <= '0;
            r_iter     <= '0;
            r_pend_val <= '0;
            r_pend_vld <= 1'b0;
            mode       <= 1'b0;
            blink      <= '0;
            x1         <= '0;
            x2         <= '0;
            x3         <= '0;
            x4         <= '0;
        end else begin
            // Sequencer. The pending slot is cleared when consumed; a new
            // value write later in this block re-arms it (latest wins).
            case (r_state)
                IDLE: begin
                    if (!mode && r_pend_vld) begin
                        r_bin      <= r_pend_val;
                        r_bcd      <= '0;
                        r_iter     <= '0;
                        r_pend_vld <= 1'b0;
                        r_state    <= SHIFT;
                    end else if (mode && dbg_req) begin
                        r_bin   <= w_dbg_sat;
                        r_bcd   <= '0;
                        r_iter  <= '0;
                        r_state <= SHIFT;
                    end
                end
                SHIFT: begin
                    r_bcd  <= w_bcd_next;
                    r_bin  <= w_bin_next;
                    r_iter <= r_iter + 4'd1;
                    if (r_iter == 4'(ITER - 1)) begin
                        r_state <= DONE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase

            // MMIO register writes
            if (cpu_we) begin
                case (cpu_addr)
                    ADDR_VAL: begin
                        if (!mode) begin
                            r_pend_val <= w_cpu_sat;
                            r_pend_vld <= 1'b1;
                        end
                    end
                    ADDR_BLINK: begin
                        blink <= cpu_wdata[3:0];
                    end
                    ADDR_MODE: begin
                        mode <= cpu_wdata[0];
                        // Handing the display to debug drops any queued value.
                        if (cpu_wdata[0]) begin
                            r_pend_vld <= 1'b0;
                        end
                    end
                    default: begin
                        if (!mode) begin
                            x1 <= cpu_wdata[3:0];
                            x2 <= cpu_wdata[7:4];
                            x3 <= cpu_wdata[11:8];
                            x4 <= cpu_wdata[15:12];
                        end
                    end
                endcase
            end

            // Conversion result is assigned last so it wins over a raw write
            // landing in the same cycle.
            if (r_state == DONE) begin
                x1 <= r_bcd[3:0];
                x2 <= r_bcd[7:4];
                x3 <= r_bcd[11:8];
                x4 <= r_bcd[15:12];
            end
        end
    end

endmodule : disp_ctrl
`default_nettype wire

// File: tb/tb_disp_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_disp_ctrl
// Description : Scoreboard bench for disp_ctrl. Stimulus pushes the expected
//               decimal digits of every value that should reach the display;
//               a monitor pops and compares whenever a conversion finishes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_disp_ctrl;

    logic        clock;
    logic        reset_n;
    logic        cpu_we;
    logic [1:0]  cpu_addr;
    logic [31:0] cpu_wdata;
    logic        dbg_req;
    logic [13:0] dbg_value;
    logic        dbg_ack;
    logic        busy;
    logic        mode;
    logic [3:0]  x1, x2, x3, x4;
    logic [3:0]  blink;

    int checks = 0;
    int errors = 0;
    int ack_cnt = 0;
    int busy_len = 0;
    logic prev_busy = 1'b0;
    logic [15:0] exp_q[$];

    disp_ctrl dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .dbg_req   (dbg_req),
        .dbg_value (dbg_value),
        .dbg_ack   (dbg_ack),
        .busy      (busy),
        .mode      (mode),
        .x1        (x1),
        .x2        (x2),
        .x3        (x3),
        .x4        (x4),
        .blink     (blink)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Decimal digits of a value after clamping to 9999, packed x4..x1.
    function automatic logic [15:0] exp_digits(input longint unsigned v);
        longint unsigned s;
        s = (v > 64'd9999) ? 64'd9999 : v;
        return {4'(s / 1000), 4'((s / 100) % 10), 4'((s / 10) % 10), 4'(s % 10)};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: a busy 1->0 transition outside reset marks a finished
    // conversion; the displayed digits must match the oldest expectation,
    // and busy must have lasted 14 shift cycles plus the write-back cycle.
    always @(negedge clock) begin
        if (!reset_n) begin
            prev_busy = 1'b0;
            busy_len  = 0;
        end else begin
            if (dbg_ack) ack_cnt++;
            if (prev_busy && !busy) begin
                if (exp_q.size() == 0) begin
                    chk("sb_underflow", {16'd0, x4, x3, x2, x1}, 32'hFFFF_FFFF);
                end else begin
                    chk("sb_digits", {16'd0, x4, x3, x2, x1}, {16'd0, exp_q.pop_front()});
                end
                chk("busy_len", busy_len, 15);
            end
            if (busy) busy_len = prev_busy ? busy_len + 1 : 1;
            prev_busy = busy;
        end
    end

    task automatic cpu_write(input logic [1:0] a, input logic [31:0] d);
        @(posedge clock); #1;
        cpu_we = 1'b1; cpu_addr = a; cpu_wdata = d;
        @(posedge clock); #1;
        cpu_we = 1'b0;
    endtask

    // Wait until the block has been idle for three consecutive cycles.
    task automatic wait_quiet();
        int quiet = 0;
        for (int n = 0; n < 300 && quiet < 3; n++) begin
            @(negedge clock);
            quiet = busy ? 0 : quiet + 1;
        end
        if (quiet < 3) chk("timeout_quiet", {31'd0, busy}, 32'd0);
    endtask

    task automatic cpu_convert(input logic [31:0] v);
        exp_q.push_back(exp_digits(longint'(v)));
        cpu_write(disp_pkg::ADDR_VAL, v);
        wait_quiet();
    endtask

    task automatic dbg_convert(input logic [13:0] v);
        bit seen = 0;
        exp_q.push_back(exp_digits(longint'(v)));
        @(posedge clock); #1;
        dbg_value = v; dbg_req = 1'b1;
        for (int n = 0; n < 20 && !seen; n++) begin
            @(negedge clock);
            seen = dbg_ack;
        end
        if (!seen) chk("timeout_ack", 32'd0, 32'd1);
        @(posedge clock); #1;
        dbg_req = 1'b0;
        wait_quiet();
    endtask

    initial begin
        logic [31:0] v;
        int ack_before;
        reset_n = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        dbg_req = 1'b0; dbg_value = '0;
        repeat (3) @(posedge clock);
        #1 reset_n = 1'b1;
        @(negedge clock);
        chk("reset_digits", {16'd0, x4, x3, x2, x1}, 32'd0);
        chk("reset_ctrl", {27'd0, blink, mode}, 32'd0);
        chk("reset_busy_ack", {30'd0, busy, dbg_ack}, 32'd0);

        cpu_convert(32'd1234);
        cpu_convert(32'd50000);
        cpu_convert(32'h0001_0000);   // low bits zero, still saturates

        // Latest wins: 7 is overwritten by 42 before the slot is consumed.
        exp_q.push_back(exp_digits(1000));
        cpu_write(disp_pkg::ADDR_VAL, 32'd1000);
        repeat (3) @(posedge clock);
        cpu_write(disp_pkg::ADDR_VAL, 32'd7);
        @(posedge clock);
        cpu_write(disp_pkg::ADDR_VAL, 32'd42);
        exp_q.push_back(exp_digits(42));
        wait_quiet();

        // Raw digits and blink mask in IDLE.
        cpu_write(disp_pkg::ADDR_RAW, 32'h0000_9021);
        @(negedge clock);
        chk("raw_idle", {16'd0, x4, x3, x2, x1}, 32'h9021);
        cpu_write(disp_pkg::ADDR_BLINK, 32'hA);
        @(negedge clock);
        chk("blink", {28'd0, blink}, 32'hA);

        // Raw write during SHIFT holds until the result replaces it.
        exp_q.push_back(exp_digits(500));
        cpu_write(disp_pkg::ADDR_VAL, 32'd500);
        repeat (4) @(posedge clock);
        cpu_write(disp_pkg::ADDR_RAW, 32'h0000_1111);
        @(negedge clock);
        chk("raw_in_shift", {16'd0, x4, x3, x2, x1}, 32'h1111);
        wait_quiet();

        for (int i = 0; i < 8; i++) begin
            v = (i % 2 == 0) ? 32'($urandom_range(0, 9999)) : 32'($urandom);
            cpu_convert(v);
        end

        // Debug ownership.
        cpu_write(disp_pkg::ADDR_MODE, 32'd1);
        @(negedge clock);
        chk("mode_set", {31'd0, mode}, 32'd1);
        ack_before = ack_cnt;
        dbg_convert(14'd305);
        chk("ack_once", ack_cnt - ack_before, 1);
        chk("dbg_digits", {16'd0, x4, x3, x2, x1}, 32'h0305);
        cpu_write(disp_pkg::ADDR_VAL, 32'd88);
        cpu_write(disp_pkg::ADDR_RAW, 32'h0000_4444);
        repeat (25) @(negedge clock);
        chk("mode1_ignore", {15'd0, busy, x4, x3, x2, x1}, 32'h0305);
        for (int i = 0; i < 3; i++) dbg_convert(14'($urandom));

        // Back to CPU: debug requests are never acknowledged.
        cpu_write(disp_pkg::ADDR_MODE, 32'd0);
        ack_before = ack_cnt;
        dbg_value = 14'd77; dbg_req = 1'b1;
        repeat (10) @(negedge clock);
        dbg_req = 1'b0;
        chk("no_ack_mode0", ack_cnt - ack_before, 0);
        chk("no_busy_mode0", {31'd0, busy}, 32'd0);

        // Reset after five iterations, with another value pending.
        cpu_write(disp_pkg::ADDR_VAL, 32'd1234);
        cpu_write(disp_pkg::ADDR_VAL, 32'd77);
        repeat (4) @(posedge clock);
        #1 reset_n = 1'b0;
        @(posedge clock);
        #1 reset_n = 1'b1;
        repeat (30) @(negedge clock);
        chk("reset_mid_digits", {16'd0, x4, x3, x2, x1}, 32'd0);
        chk("reset_mid_state", {27'd0, blink, busy}, 32'd0);
        chk("sb_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_disp_ctrl
`default_nettype wire

// File: doc/disp_ctrl.md
Name: disp_ctrl

Overview:
- Control and sequencing block for the 4-digit seven-segment display driver.
- Owns the digit registers and the blink mask. Shares the display between two requesters: the CPU MMIO store port and a debug value source.
- Converts binary values to BCD with a multi-cycle double-dabble sequencer.
- Outputs x1..x4 and blink drive the display driver's digit and switch inputs directly. x1 is the units digit; x4 is the thousands digit.

Parameters:
- VAL_W, 14, binary value width; inputs above 9999 saturate to 9999.
- MAX_VAL, 9999, saturation limit.

Ports:
- clock  in  1  system clock
- reset_n  in  1  reset; synchronous, active-low
- cpu_we  in  1  MMIO write strobe, single cycle
- cpu_addr  in  2  register select: 0 value, 1 blink, 2 mode, 3 raw BCD
- cpu_wdata  in  32  write data
- dbg_req  in  1  debug update request, level; held until dbg_ack
- dbg_value  in  14  debug binary value, sampled on the dbg_ack cycle
- dbg_ack  out  1  one-cycle pulse when the debug request is accepted
- busy  out  1  conversion in progress (state != IDLE)
- mode  out  1  0 = CPU owns the display, 1 = debug owns it
- x1, x2, x3, x4  out  4 each  BCD digits, units..thousands
- blink  out  4  per-digit blink mask (bit0 = x1)

Behaviour:
- Reset, while reset_n=0 at a clock edge:
  - x1..x4=0, blink=0, mode=0, dbg_ack=0, busy=0.
  - State=IDLE; pending slot cleared; any in-flight conversion is aborted and its digits are not written.
- Register writes (cpu_we=1):
  - addr1: blink <= wdata[3:0] next cycle.
  - addr2: mode <= wdata[0] next cycle.
  - addr3: when mode=0, x1..x4 <= wdata[3:0],[7:4],[11:8],[15:12] next cycle. Nibbles above 9 are stored unchanged, since the driver blanks them.
  - addr0: binary value wdata[13:0]. If wdata[31:0] > 9999, the value saturates to 9999.
  - addr0 and addr3 are ignored when mode=1. addr1 and addr2 always take effect.
- Pending slot: one entry, plus a valid bit.
  - An addr0 write with mode=0 goes to the pending slot. If the slot is already valid, the new value overwrites it (latest wins).
  - A write in the same cycle as the pending slot is consumed: the new value stays pending, and the consumed value is converted.
- FSM states: IDLE, SHIFT, DONE.
  - IDLE: selects a source.
    - mode=0: pending slot if valid. Debug requests are never acked; dbg_ack stays 0.
    - mode=1: dbg_req. dbg_ack pulses in that cycle and dbg_value is saturated and latched.
    - When a source is selected: load the shift register (binary value, BCD=0), clear the iteration counter, go to SHIFT.
  - SHIFT: 14 cycles, one double-dabble iteration per cycle. In each cycle, every BCD nibble >=5 gets +3, then the combined {bcd,bin} shifts left by 1. After the 14th cycle, go to DONE.
  - DONE: write x1..x4 from the BCD result, go to IDLE.
- Latency: 16 cycles from the accept cycle (IDLE) to x1..x4 valid. busy=1 throughout SHIFT and DONE.
- Precedence:
  - A raw addr3 write landing in DONE is overwritten by the conversion result.
  - A raw addr3 write landing during SHIFT is kept until DONE overwrites it.
- Mode change mid-conversion: the conversion completes and writes its result.
- Switching to mode=1 discards the pending slot.

Decomposition:
- Shared package disp_pkg holds:
  - address constants ADDR_VAL=0, ADDR_BLINK=1, ADDR_MODE=2, ADDR_RAW=3;
  - MAX_VAL=9999;
  - FSM state encoding (IDLE/SHIFT/DONE, 2 bits);
  - ITER=14.
- One sub-module, bin2bcd_step: combinational single double-dabble iteration (16-bit BCD plus 14-bit binary in, shifted pair out).
- disp_ctrl instantiates bin2bcd_step once and keeps the FSM, arbitration and registers.

Test Plan:
- Reset, then CPU addr0 write 1234 -> busy rises next cycle. 16 cycles after the write: x4=1, x3=2, x2=3, x1=4, busy=0.
- CPU addr0 write 50000 -> saturates; result x4..x1 = 9,9,9,9.
- addr0 write 7 during a conversion, then 42 two cycles later:
  - first conversion completes unchanged;
  - next conversion converts 42 (x2=4, x1=2);
  - 7 is never displayed.
- Debug arbitration:
  - addr2 write 1, then dbg_req=1 with dbg_value=305 -> dbg_ack pulses exactly once; digits become 0,3,0,5.
  - An addr0 write of 88 in mode=1 is ignored.
  - In mode=0, dbg_req=1 yields no dbg_ack.
- addr3 write 0x0000_9021 in IDLE -> next cycle x4=9, x3=0, x2=2, x1=1. addr1 write 0xA -> blink=4'b1010.
- Reset mid-SHIFT (after 5 iterations of 1234) -> x1..x4 stay 0, busy=0, pending cleared; no later digit update.
